updown_counter_mod: RTL and testbench

- Parametrised successor to the fixed 4-bit up-counter: WIDTH-bit counter with programmable modulus, up/down direction, count enable, parallel load, and wrap or saturate mode.
- Used as the general-purpose counter/timer primitive in the hw datapaths: dividers, BCD digits, event counters.
- Provides a registered count, a combinational terminal-count flag and a registered one-cycle wrap/saturate event pulse for cascading.

---
 rtl/counter_pkg.sv | 31 +++
 rtl/updown_counter_mod_if.sv | 27 ++
 rtl/counter_next_state.sv | 54 +++++
 rtl/updown_counter_mod.sv | 96 +++++++++
 tb/tb_updown_counter_mod.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality helper for the up/down counter family.
package counter_pkg;

  // Counting mode selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Direction encoding on up_dn
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // True when a parameter set describes a buildable counter
  function automatic bit params_legal(input int width, input int modulus,
                                      input int reset_value, input int saturate);
    bit ok;
    ok = 1'b1;
    if ((width < 2) || (width > 16)) begin
      ok = 1'b0;
    end else if ((modulus < 2) || (modulus > (32'sd1 << width))) begin
      ok = 1'b0;
    end else if ((reset_value < 0) || (reset_value >= modulus)) begin
      ok = 1'b0;
    end else if ((saturate != MODE_WRAP) && (saturate != MODE_SAT)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle of one counter stage.
interface updown_counter_mod_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_output;
  logic             tc;
  logic             event_pulse;
  logic             load_err;

  // Controller side: drives the strobes, observes count and flags
  modport master (
    output en, up_dn, load, load_value,
    input  count_output, tc, event_pulse, load_err
  );

  // Counter side
  modport slave (
    input  en, up_dn, load, load_value,
    output count_output, tc, event_pulse, load_err
  );

endinterface

// File: rtl/counter_next_state.sv
// Combinational step function: next count for one enabled step and whether
// that step hit a limit (wrap, saturate, or recovery from an out-of-range value).
module counter_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_limit_hit
);

  // One extra bit keeps MODULUS == 2**WIDTH comparisons free of aliasing
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH:0] w_count_ext;

  assign w_count_ext = {1'b0, i_count};

  // Select the step result; out-of-range counts recover to 0 (up) or MAX (down)
  always_comb begin
    o_next_count = i_count;
    o_limit_hit  = 1'b0;
    if (i_up_dn == DIR_UP) begin
      if (w_count_ext < MAX_EXT) begin
        o_next_count = WIDTH'(w_count_ext + (WIDTH+1)'(1));
        o_limit_hit  = 1'b0;
      end else if (w_count_ext == MAX_EXT) begin
        o_next_count = SAT_MODE ? MAX_VAL : {WIDTH{1'b0}};
        o_limit_hit  = 1'b1;
      end else begin
        o_next_count = {WIDTH{1'b0}};
        o_limit_hit  = 1'b1;
      end
    end else begin
      if (w_count_ext == {(WIDTH+1){1'b0}}) begin
        o_next_count = SAT_MODE ? {WIDTH{1'b0}} : MAX_VAL;
        o_limit_hit  = 1'b1;
      end else if (w_count_ext > MAX_EXT) begin
        o_next_count = MAX_VAL;
        o_limit_hit  = 1'b1;
      end else begin
        o_next_count = WIDTH'(w_count_ext - (WIDTH+1)'(1));
        o_limit_hit  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-N up/down counter with enable, clamped parallel load, wrap or
// saturate mode, combinational terminal count and registered event flags.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_counter_mod_if.slave  bus
);

  localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_VAL   = WIDTH'(RESET_VALUE);

  // Reject unbuildable parameter sets at elaboration
  if (!params_legal(WIDTH, MODULUS, RESET_VALUE, SATURATE)) begin : g_param_error
    $error("updown_counter_mod: illegal WIDTH/MODULUS/RESET_VALUE/SATURATE");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_event_pulse;
  logic             r_load_err;

  logic [WIDTH-1:0] w_next_count;
  logic             w_limit_hit;
  logic             w_load_oob;
  logic [WIDTH-1:0] w_load_target;
  logic             w_tc;

  counter_next_state #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next_state (
    .i_count      (r_count),
    .i_up_dn      (bus.up_dn),
    .o_next_count (w_next_count),
    .o_limit_hit  (w_limit_hit)
  );

  assign w_load_oob = ({1'b0, bus.load_value} >= MODULUS_EXT);

  // Clamp out-of-range load values to the top of the range
  always_comb begin
    w_load_target = bus.load_value;
    if (w_load_oob) begin
      w_load_target = MAX_VAL;
    end else begin
      w_load_target = bus.load_value;
    end
  end

  // Terminal count: the next enabled step would wrap or saturate
  always_comb begin
    w_tc = 1'b0;
    if (!bus.en) begin
      w_tc = 1'b0;
    end else if (bus.up_dn == DIR_UP) begin
      w_tc = (r_count == MAX_VAL);
    end else begin
      w_tc = (r_count == {WIDTH{1'b0}});
    end
  end

  // Count register and one-cycle flags; reset > load > enable > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= RESET_VAL;
      r_event_pulse <= 1'b0;
      r_load_err    <= 1'b0;
    end else if (bus.load) begin
      r_count       <= w_load_target;
      r_event_pulse <= 1'b0;
      r_load_err    <= w_load_oob;
    end else if (bus.en) begin
      r_count       <= w_next_count;
      r_event_pulse <= w_limit_hit;
      r_load_err    <= 1'b0;
    end else begin
      r_count       <= r_count;
      r_event_pulse <= 1'b0;
      r_load_err    <= 1'b0;
    end
  end

  assign bus.count_output = r_count;
  assign bus.tc           = w_tc;
  assign bus.event_pulse  = r_event_pulse;
  assign bus.load_err     = r_load_err;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench: wrap and saturate stages at MODULUS=10, plus a two-stage
// MODULUS=16 cascade chained through tc.
module tb_updown_counter_mod;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.WIDTH(4)) if_a  ();
  updown_counter_mod_if #(.WIDTH(4)) if_s  ();
  updown_counter_mod_if #(.WIDTH(4)) if_lo ();
  updown_counter_mod_if #(.WIDTH(4)) if_hi ();

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3), .SATURATE(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(1))
    dut_s (.clk(clk), .reset(reset), .bus(if_s));
  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0), .SATURATE(0))
    dut_lo (.clk(clk), .reset(reset), .bus(if_lo));
  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0), .SATURATE(0))
    dut_hi (.clk(clk), .reset(reset), .bus(if_hi));

  assign if_hi.en         = if_lo.tc & if_lo.en;
  assign if_hi.up_dn      = 1'b1;
  assign if_hi.load       = 1'b0;
  assign if_hi.load_value = 4'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.en = 1'b1; if_a.up_dn = 1'b1; if_a.load = 1'b1; if_a.load_value = 4'd7;
    if_s.en = 1'b0; if_s.up_dn = 1'b1; if_s.load = 1'b0; if_s.load_value = 4'd0;
    if_lo.en = 1'b0; if_lo.up_dn = 1'b1; if_lo.load = 1'b0; if_lo.load_value = 4'd0;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (if_a.count_output !== 4'd3) begin
      n_err++; $display("FAIL reset_cnt_1: got %0d, expected 3", if_a.count_output);
    end
    tick();
    n_cmp++;
    if (if_a.count_output !== 4'd3) begin
      n_err++; $display("FAIL reset_cnt_2: got %0d, expected 3", if_a.count_output);
    end
    n_cmp++;
    if (if_a.event_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_ev: got %0b, expected 0", if_a.event_pulse);
    end
    n_cmp++;
    if (if_a.load_err !== 1'b0) begin
      n_err++; $display("FAIL reset_lerr: got %0b, expected 0", if_a.load_err);
    end
    n_cmp++;
    if (if_hi.count_output !== 4'd0) begin
      n_err++; $display("FAIL reset_hi: got %0d, expected 0", if_hi.count_output);
    end
    if_a.en = 1'b0; if_a.load = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_cnt [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    logic       exp_ev  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_tc  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_a.load = 1'b1; if_a.load_value = 4'd0;
    tick();
    n_cmp++;
    if (if_a.count_output !== 4'd0) begin
      n_err++; $display("FAIL upw_load0: got %0d, expected 0", if_a.count_output);
    end
    if_a.load = 1'b0; if_a.en = 1'b1; if_a.up_dn = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      n_cmp++;
      if (if_a.tc !== exp_tc[k]) begin
        n_err++; $display("FAIL upw_tc[%0d]: got %0b, expected %0b", k, if_a.tc, exp_tc[k]);
      end
      tick();
      n_cmp++;
      if (if_a.count_output !== exp_cnt[k]) begin
        n_err++; $display("FAIL upw_cnt[%0d]: got %0d, expected %0d", k, if_a.count_output, exp_cnt[k]);
      end
      n_cmp++;
      if (if_a.event_pulse !== exp_ev[k]) begin
        n_err++; $display("FAIL upw_ev[%0d]: got %0b, expected %0b", k, if_a.event_pulse, exp_ev[k]);
      end
    end
    if_a.en = 1'b0;
  endtask

  task automatic test_down_dir();
    logic [3:0] exp_cnt [4] = '{4'd1, 4'd0, 4'd9, 4'd0};
    logic       exp_ev  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       dir     [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    if_a.load = 1'b1; if_a.load_value = 4'd2;
    tick();
    n_cmp++;
    if (if_a.count_output !== 4'd2) begin
      n_err++; $display("FAIL dn_load2: got %0d, expected 2", if_a.count_output);
    end
    if_a.load = 1'b0; if_a.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_a.up_dn = dir[k];
      #1;
      n_cmp++;
      if (if_a.tc !== exp_tc[k]) begin
        n_err++; $display("FAIL dn_tc[%0d]: got %0b, expected %0b", k, if_a.tc, exp_tc[k]);
      end
      tick();
      n_cmp++;
      if (if_a.count_output !== exp_cnt[k]) begin
        n_err++; $display("FAIL dn_cnt[%0d]: got %0d, expected %0d", k, if_a.count_output, exp_cnt[k]);
      end
      n_cmp++;
      if (if_a.event_pulse !== exp_ev[k]) begin
        n_err++; $display("FAIL dn_ev[%0d]: got %0b, expected %0b", k, if_a.event_pulse, exp_ev[k]);
      end
    end
    // At 0 counting down but disabled: tc gated off, count holds
    if_a.en = 1'b0; if_a.up_dn = 1'b0;
    #1;
    n_cmp++;
    if (if_a.tc !== 1'b0) begin
      n_err++; $display("FAIL hold_tc: got %0b, expected 0", if_a.tc);
    end
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd0) || (if_a.event_pulse !== 1'b0)) begin
      n_err++; $display("FAIL hold_cnt_ev: got %0d/%0b, expected 0/0", if_a.count_output, if_a.event_pulse);
    end
  endtask

  task automatic test_saturate();
    if_s.load = 1'b1; if_s.load_value = 4'd9;
    tick();
    if_s.load = 1'b0; if_s.en = 1'b1; if_s.up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ((if_s.count_output !== 4'd9) || (if_s.event_pulse !== 1'b1)) begin
        n_err++; $display("FAIL sat_up[%0d]: got %0d/%0b, expected 9/1", k, if_s.count_output, if_s.event_pulse);
      end
    end
    // Load wins over enable and suppresses the pulse
    if_s.load = 1'b1; if_s.load_value = 4'd0; if_s.up_dn = 1'b0;
    tick();
    n_cmp++;
    if ((if_s.count_output !== 4'd0) || (if_s.event_pulse !== 1'b0)) begin
      n_err++; $display("FAIL sat_load0: got %0d/%0b, expected 0/0", if_s.count_output, if_s.event_pulse);
    end
    if_s.load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ((if_s.count_output !== 4'd0) || (if_s.event_pulse !== 1'b1)) begin
        n_err++; $display("FAIL sat_dn[%0d]: got %0d/%0b, expected 0/1", k, if_s.count_output, if_s.event_pulse);
      end
    end
    if_s.en = 1'b0;
    tick();
    n_cmp++;
    if (if_s.event_pulse !== 1'b0) begin
      n_err++; $display("FAIL sat_idle_ev: got %0b, expected 0", if_s.event_pulse);
    end
  endtask

  task automatic test_load();
    if_a.load = 1'b1; if_a.load_value = 4'd9; if_a.en = 1'b0;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd9) || (if_a.load_err !== 1'b0)) begin
      n_err++; $display("FAIL ld9: got %0d/%0b, expected 9/0", if_a.count_output, if_a.load_err);
    end
    // At 9 counting up: a plain step would wrap, but load has priority
    if_a.load_value = 4'd12; if_a.en = 1'b1; if_a.up_dn = 1'b1;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd9) || (if_a.load_err !== 1'b1) || (if_a.event_pulse !== 1'b0)) begin
      n_err++; $display("FAIL ld12_clamp: got %0d/%0b/%0b, expected 9/1/0",
                        if_a.count_output, if_a.load_err, if_a.event_pulse);
    end
    if_a.load = 1'b0; if_a.en = 1'b0;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd9) || (if_a.load_err !== 1'b0)) begin
      n_err++; $display("FAIL ld_err_drop: got %0d/%0b, expected 9/0", if_a.count_output, if_a.load_err);
    end
    if_a.load = 1'b1; if_a.load_value = 4'd10; if_a.en = 1'b1; if_a.up_dn = 1'b0;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd9) || (if_a.load_err !== 1'b1)) begin
      n_err++; $display("FAIL ld10_clamp: got %0d/%0b, expected 9/1", if_a.count_output, if_a.load_err);
    end
    if_a.load_value = 4'd5;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd5) || (if_a.load_err !== 1'b0)) begin
      n_err++; $display("FAIL ld5: got %0d/%0b, expected 5/0", if_a.count_output, if_a.load_err);
    end
    // Reset beats a load in the same cycle
    if_a.load_value = 4'd5; reset = 1'b1;
    tick();
    n_cmp++;
    if ((if_a.count_output !== 4'd3) || (if_a.load_err !== 1'b0)) begin
      n_err++; $display("FAIL rst_over_ld: got %0d/%0b, expected 3/0", if_a.count_output, if_a.load_err);
    end
    reset = 1'b0; if_a.load = 1'b0; if_a.en = 1'b0;
  endtask

  task automatic test_cascade();
    int lo_events = 0;
    int hi_events = 0;
    if_lo.en = 1'b1; if_lo.up_dn = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (if_lo.event_pulse === 1'b1) lo_events++;
      if (if_hi.event_pulse === 1'b1) hi_events++;
      n_cmp++;
      if (if_lo.count_output !== 4'(k % 16)) begin
        n_err++; $display("FAIL cas_lo[%0d]: got %0d, expected %0d", k, if_lo.count_output, k % 16);
      end
      n_cmp++;
      if (if_hi.count_output !== 4'((k / 16) % 16)) begin
        n_err++; $display("FAIL cas_hi[%0d]: got %0d, expected %0d", k, if_hi.count_output, (k / 16) % 16);
      end
      n_cmp++;
      if (if_hi.event_pulse !== ((k == 256) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL cas_hi_ev[%0d]: got %0b, expected %0b", k, if_hi.event_pulse, (k == 256));
      end
    end
    if_lo.en = 1'b0;
    n_cmp++;
    if (lo_events != 16) begin
      n_err++; $display("FAIL cas_lo_events: got %0d, expected 16", lo_events);
    end
    n_cmp++;
    if (hi_events != 1) begin
      n_err++; $display("FAIL cas_hi_events: got %0d, expected 1", hi_events);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_dir();
    test_saturate();
    test_load();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
